// File: rtl/craps_pkg.sv
// craps_pkg: shared types and constants for the craps datapath stages
// (dice roller, classifier, point tracker).
//   state_t   : dice-roller FSM states
//   LFSR_MASK : Galois feedback taps of the 16-bit LFSR
//   DIE_MIN/MAX, SUM_W : die face range and width of the dice sum
package craps_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TUMBLE   = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [2:0]  DIE_MIN   = 3'd1;
  localparam logic [2:0]  DIE_MAX   = 3'd6;
  localparam int unsigned SUM_W     = 4;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : '0);
  endfunction

  // Rejection sampling: raw values 6 and 7 are discarded and the face holds,
  // keeping the six faces equiprobable.
  function automatic logic [2:0] die_sample(input logic [2:0] raw,
                                            input logic [2:0] held);
    return (raw < DIE_MAX) ? 3'(raw + DIE_MIN) : held;
  endfunction

  function automatic logic [SUM_W-1:0] die_sum(input logic [2:0] a,
                                               input logic [2:0] b);
    return SUM_W'(a) + SUM_W'(b);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, shifts right every cycle.
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads SEED
//   value : current LFSR state (never zero)
module lfsr16
  import craps_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);

  // An all-zero state would lock the LFSR up, so a zero seed becomes 1.
  localparam logic [15:0] RESET_VAL = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= RESET_VAL;
    end else begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/craps_dice_roller.sv
// craps_dice_roller: on a roll request tumbles two dice for ROLL_CYCLES
// cycles, then presents both faces, their sum and a valid flag. Holding
// the button yields one roll; re-arming needs roll low after the result.
//   clk, rst_n : clock, asynchronous active-low reset
//   roll       : debounced roll request level
//   die1, die2 : faces 1..6
//   sum        : die1 + die2 once valid
//   valid      : outputs hold a completed roll
//   busy       : high while tumbling
module craps_dice_roller
  import craps_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned ROLL_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       roll,
  output logic [2:0] die1,
  output logic [2:0] die2,
  output logic [3:0] sum,
  output logic       valid,
  output logic       busy
);

  localparam logic [7:0] CNT_INIT = 8'(ROLL_CYCLES - 1);

  logic [15:0] lfsr;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  die1_d, die2_d;
  logic [3:0]  sum_d;
  logic        valid_d, busy_d;

  // Bits of the LFSR not consumed by the dice.
  logic        unused_lfsr_bits;
  assign unused_lfsr_bits = ^{lfsr[15:11], lfsr[7:3]};

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .value(lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      die1    <= DIE_MIN;
      die2    <= DIE_MIN;
      sum     <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      die1    <= die1_d;
      die2    <= die2_d;
      sum     <= sum_d;
      valid   <= valid_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    die1_d  = die1;
    die2_d  = die2;
    sum_d   = sum;
    valid_d = valid;
    busy_d  = busy;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (roll) begin
          state_d = TUMBLE;
          cnt_d   = CNT_INIT;
          valid_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      TUMBLE: begin
        die1_d = die_sample(lfsr[2:0], die1);
        die2_d = die_sample(lfsr[10:8], die2);
        if (cnt_q == '0) begin
          state_d = WAIT_REL;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          // Sum of the faces written on this same edge, not the old ones.
          sum_d   = die_sum(die1_d, die2_d);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WAIT_REL: begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
        if (!roll) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_craps_dice_roller.sv
// Self-checking bench for craps_dice_roller: table-driven roll scenarios,
// hand-written reset sequences and a randomized statistics run, checked
// against a model that replays the LFSR sequence indexed by clock edges.
module tb_craps_dice_roller;

  localparam int          RC   = 8;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          PER  = 65535;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       roll;
  logic [2:0] die1, die2;
  logic [3:0] sum;
  logic       valid, busy;

  always #5 clk = ~clk;

  craps_dice_roller #(
    .LFSR_SEED  (SEED),
    .ROLL_CYCLES(RC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .roll (roll),
    .die1 (die1),
    .die2 (die2),
    .sum  (sum),
    .valid(valid),
    .busy (busy)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned edge_n = 0;
  logic [15:0] seq [0:PER-1];
  int          m_d1, m_d2;
  int          face1 [1:6];
  int          face2 [1:6];
  int          sum7 = 0;
  int          sum_bad = 0;

  typedef struct {
    int idle_before;
    int hold_after;
    bit poke;
    int exp_busy;
    int exp_valid;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Dice after a roll accepted at edge t: the tumble edges t+1..t+RC each
  // see LFSR value number (edge index) since reset release.
  task automatic predict(input int unsigned t);
    logic [15:0] v;
    for (int i = 1; i <= RC; i++) begin
      v = seq[(t + i) % PER];
      if (v[2:0] < 3'd6) m_d1 = int'(v[2:0]) + 1;
      if (v[10:8] < 3'd6) m_d2 = int'(v[10:8]) + 1;
    end
  endtask

  task automatic model_reset();
    edge_n = 0;
    m_d1   = 1;
    m_d2   = 1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_die1"}, die1, 1);
    chk({tag, "_die2"}, die2, 1);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic apply_reset();
    roll  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_roll(input int idle_before, input int hold_after,
                          input bit poke, output int busy_cycles);
    int unsigned t;
    int k;
    int vbad;
    int hbad;
    roll = 1'b0;
    repeat (idle_before) tick();
    chk("idle_busy", busy, 0);
    roll = 1'b1;
    t    = edge_n;
    tick();
    predict(t);
    busy_cycles = 0;
    vbad = 0;
    k = 0;
    while (busy && k < 300) begin
      busy_cycles++;
      if (valid) vbad++;
      roll = (hold_after > 0) ? 1'b1 : (poke ? 1'($urandom) : 1'b0);
      tick();
      k++;
    end
    if (k >= 300) chk("tumble_timeout", k, 0);
    chk("valid_low_in_tumble", vbad, 0);
    chk("valid_after_tumble", valid, 1);
    chk("die1", die1, m_d1);
    chk("die2", die2, m_d2);
    chk("sum", sum, m_d1 + m_d2);
    if (sum < 2 || sum > 12) sum_bad++;
    hbad = 0;
    repeat (hold_after) begin
      roll = 1'b1;
      tick();
      if (busy || !valid) hbad++;
    end
    chk("held_no_reroll", hbad, 0);
    roll = 1'b0;
    tick();
    chk("released_valid", valid, 1);
  endtask

  initial begin
    int bc;
    seq[0] = SEED;
    for (int i = 1; i < PER; i++)
      seq[i] = (seq[i-1] >> 1) ^ (seq[i-1][0] ? 16'hB400 : 16'h0000);
    for (int f = 1; f <= 6; f++) begin
      face1[f] = 0;
      face2[f] = 0;
    end

    vecs[0] = '{idle_before: 0, hold_after: 0,  poke: 1'b0, exp_busy: RC, exp_valid: 1};
    vecs[1] = '{idle_before: 3, hold_after: 0,  poke: 1'b0, exp_busy: RC, exp_valid: 1};
    vecs[2] = '{idle_before: 1, hold_after: 0,  poke: 1'b1, exp_busy: RC, exp_valid: 1};
    vecs[3] = '{idle_before: 0, hold_after: 41, poke: 1'b0, exp_busy: RC, exp_valid: 1};
    vecs[4] = '{idle_before: 0, hold_after: 0,  poke: 1'b0, exp_busy: RC, exp_valid: 1};
    vecs[5] = '{idle_before: 5, hold_after: 2,  poke: 1'b1, exp_busy: RC, exp_valid: 1};

    apply_reset();

    for (int v = 0; v < 6; v++) begin
      run_roll(vecs[v].idle_before, vecs[v].hold_after, vecs[v].poke, bc);
      chk($sformatf("vec%0d_busy_cycles", v), bc, vecs[v].exp_busy);
      chk($sformatf("vec%0d_valid", v), valid, vecs[v].exp_valid);
    end

    // Roll held from reset: one roll, then parked with busy low.
    apply_reset();
    roll = 1'b1;
    begin
      int rises = 0;
      int busy_rises = 0;
      logic pv = 1'b0;
      logic pb = 1'b0;
      for (int i = 0; i < 50; i++) begin
        tick();
        if (valid && !pv) rises++;
        if (busy && !pb) busy_rises++;
        pv = valid;
        pb = busy;
      end
      chk("held_valid_rises", rises, 1);
      chk("held_busy_pulses", busy_rises, 1);
      predict(0);
      chk("held_die1", die1, m_d1);
      chk("held_die2", die2, m_d2);
    end
    roll = 1'b0;
    tick();
    run_roll(0, 0, 1'b0, bc);
    chk("rearm_busy_cycles", bc, RC);

    // Reset in the middle of a tumble.
    apply_reset();
    roll = 1'b1;
    tick();
    roll = 1'b0;
    repeat (3) tick();
    chk("mid_busy_before_reset", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_roll(1, 0, 1'b0, bc);
    chk("post_reset_busy_cycles", bc, RC);

    // Randomized statistics run.
    apply_reset();
    for (int r = 0; r < 3600; r++) begin
      run_roll($urandom_range(0, 3), 0, ($urandom_range(0, 7) == 0), bc);
      if (die1 >= 1 && die1 <= 6) face1[die1]++;
      if (die2 >= 1 && die2 <= 6) face2[die2]++;
      if (sum == 4'd7) sum7++;
    end
    for (int f = 1; f <= 6; f++) begin
      chk($sformatf("face1_%0d_seen", f), int'(face1[f] > 0), 1);
      chk($sformatf("face2_%0d_seen", f), int'(face2[f] > 0), 1);
    end
    chk("sum_out_of_range", sum_bad, 0);
    chk("sum7_count_in_10_23pct", int'(sum7 >= 360 && sum7 <= 828), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
